// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the datapath and pipe_ctrl.
// master: the pipeline side; it drives hazard/memory status and takes the controls.
// slave : pipe_ctrl; it takes the status and drives enables, flush, freeze and statistics.
//   ID_EX_MemRead_i, ID_EX_Rt_i  load in EX and its destination register
//   IF_ID_Rs_i, IF_ID_Rt_i       source registers of the instruction in ID
//   branch_taken_i               branch/jump resolved taken in ID
//   mem_req_i, mem_ack_i         data-memory request and completion
//   PC_write_o, IF_ID_write_o    PC / IF-ID load enables
//   ID_EX_bubble_o               zero the ID/EX control fields
//   IF_ID_flush_o                clear IF/ID to a NOP
//   freeze_o                     hold all pipeline registers and PC
//   mem_err_o                    sticky memory-timeout flag
//   stall_cnt_o, flush_cnt_o     saturating statistics counters
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ID_EX_MemRead_i;
   logic [4:0]       ID_EX_Rt_i;
   logic [4:0]       IF_ID_Rs_i;
   logic [4:0]       IF_ID_Rt_i;
   logic             branch_taken_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             PC_write_o;
   logic             IF_ID_write_o;
   logic             ID_EX_bubble_o;
   logic             IF_ID_flush_o;
   logic             freeze_o;
   logic             mem_err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i,
             branch_taken_i, mem_req_i, mem_ack_i,
      input  PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o,
             freeze_o, mem_err_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i,
             branch_taken_i, mem_req_i, mem_ack_i,
      output PC_write_o, IF_ID_write_o, ID_EX_bubble_o, IF_ID_flush_o,
             freeze_o, mem_err_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and memory-wait controller for a 5-stage pipeline.
// Ports:
//   clk_i  single clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    pipe_ctrl_if.slave (hazard inputs, pipeline enables, error flag, statistics)
// Priority of the pipeline controls: reset > memory freeze > load-use stall > taken branch.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; an unacknowledged mem request freezes and enters MEM_WAIT
// MEM_WAIT | frozen until mem_ack_i, or until wcnt reaches MEM_TIMEOUT-1 (error)
module pipe_ctrl #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255,
   parameter int         CNT_W       = 16
) (
   input logic        clk_i,
   input logic        rst_i,
   pipe_ctrl_if.slave bus
);

   typedef enum logic {
      RUN,
      MEM_WAIT
   } state_t;

   localparam logic [7:0]       WCNT_LAST = MEM_TIMEOUT - 8'd1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       wcnt;
   logic [7:0]       wcnt_nxt;
   logic             err_set;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             lu;
   logic             freeze;
   logic             pc_write;
   logic             ifid_write;
   logic             bubble;
   logic             flush;

   // Loads into r0 never create a dependency.
   assign lu = bus.ID_EX_MemRead_i && (bus.ID_EX_Rt_i != 5'd0) &&
               ((bus.ID_EX_Rt_i == bus.IF_ID_Rs_i) || (bus.ID_EX_Rt_i == bus.IF_ID_Rt_i));

   always_comb begin
      state_nxt  = state;
      wcnt_nxt   = wcnt;
      err_set    = 1'b0;
      freeze     = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      bubble     = 1'b0;
      flush      = 1'b0;

      case (state)
         RUN: begin
            if (bus.mem_req_i && !bus.mem_ack_i) begin
               freeze    = 1'b1;
               state_nxt = MEM_WAIT;
               wcnt_nxt  = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ack_i) begin
               state_nxt = RUN;
            end else begin
               freeze = 1'b1;
               // Give up on the access; the pipeline resumes with the error flagged.
               if (wcnt == WCNT_LAST) begin
                  state_nxt = RUN;
                  err_set   = 1'b1;
                  wcnt_nxt  = 8'd0;
               end else begin
                  wcnt_nxt = wcnt + 8'd1;
               end
            end
         end
      endcase

      if (rst_i) begin
         freeze     = 1'b0;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         bubble     = 1'b1;
      end else if (freeze) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (lu) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         bubble     = 1'b1;
      end else if (bus.branch_taken_i) begin
         flush = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= RUN;
         wcnt      <= 8'd0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (err_set) begin
            mem_err <= 1'b1;
         end
         if ((freeze || lu) && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.PC_write_o     = pc_write;
   assign bus.IF_ID_write_o  = ifid_write;
   assign bus.ID_EX_bubble_o = bubble;
   assign bus.IF_ID_flush_o  = flush;
   assign bus.freeze_o       = freeze;
   assign bus.mem_err_o      = mem_err;
   assign bus.stall_cnt_o    = stall_cnt;
   assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MEM_TIMEOUT=4, CNT_W=4 so saturation is reachable).
// A cycle-level model of the control rules is compared against every output at each
// falling edge; directed scenarios add literal expectations for the key cases.
module tb_pipe_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CW      = 4;
   localparam int MAXC    = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pipe_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_ctrl #(
      .MEM_TIMEOUT(8'(TIMEOUT)),
      .CNT_W      (CW)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: consecutive frozen cycles of the current access, error flag, counters.
   int m_frozen  = 0;
   bit m_err     = 1'b0;
   int m_stalls  = 0;
   int m_flushes = 0;

   function automatic bit m_lu();
      return bus.ID_EX_MemRead_i && (bus.ID_EX_Rt_i != 5'd0) &&
             ((bus.ID_EX_Rt_i == bus.IF_ID_Rs_i) || (bus.ID_EX_Rt_i == bus.IF_ID_Rt_i));
   endfunction

   function automatic bit m_frz();
      if (m_frozen > 0) return !bus.mem_ack_i;
      return bus.mem_req_i && !bus.mem_ack_i;
   endfunction

   // An access may keep the pipe frozen for at most TIMEOUT+1 cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_frozen  <= 0;
         m_err     <= 1'b0;
         m_stalls  <= 0;
         m_flushes <= 0;
      end else begin
         if (m_frz()) begin
            if (m_frozen + 1 == TIMEOUT + 1) begin
               m_err    <= 1'b1;
               m_frozen <= 0;
            end else begin
               m_frozen <= m_frozen + 1;
            end
         end else begin
            m_frozen <= 0;
         end
         if (m_frz() || m_lu())
            m_stalls <= (m_stalls < MAXC) ? m_stalls + 1 : MAXC;
         if (!m_frz() && !m_lu() && bus.branch_taken_i)
            m_flushes <= (m_flushes < MAXC) ? m_flushes + 1 : MAXC;
      end
   end

   always @(negedge clk) begin
      bit e_pc, e_ifid, e_bub, e_fl, e_frz;
      if (rst) begin
         {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b00100;
      end else if (m_frz()) begin
         {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b00001;
      end else if (m_lu()) begin
         {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b00100;
      end else if (bus.branch_taken_i) begin
         {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b11010;
      end else begin
         {e_pc, e_ifid, e_bub, e_fl, e_frz} = 5'b11000;
      end
      chk("m_pc_write",    32'(bus.PC_write_o),     32'(e_pc));
      chk("m_ifid_write",  32'(bus.IF_ID_write_o),  32'(e_ifid));
      chk("m_bubble",      32'(bus.ID_EX_bubble_o), 32'(e_bub));
      chk("m_flush",       32'(bus.IF_ID_flush_o),  32'(e_fl));
      chk("m_freeze",      32'(bus.freeze_o),       32'(e_frz));
      chk("m_mem_err",     32'(bus.mem_err_o),      32'(m_err));
      chk("m_stall_cnt",   32'(bus.stall_cnt_o),    32'(m_stalls));
      chk("m_flush_cnt",   32'(bus.flush_cnt_o),    32'(m_flushes));
   end

   task automatic drive(input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rtid, input bit br, input bit req, input bit ack);
      bus.ID_EX_MemRead_i = mr;
      bus.ID_EX_Rt_i      = rt;
      bus.IF_ID_Rs_i      = rs;
      bus.IF_ID_Rt_i      = rtid;
      bus.branch_taken_i  = br;
      bus.mem_req_i       = req;
      bus.mem_ack_i       = ack;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Reset for one edge with a pending memory request that must not freeze.
   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      #2;
      chk("rst_pc_write", 32'(bus.PC_write_o),     0);
      chk("rst_ifid",     32'(bus.IF_ID_write_o),  0);
      chk("rst_bubble",   32'(bus.ID_EX_bubble_o), 1);
      chk("rst_flush",    32'(bus.IF_ID_flush_o),  0);
      chk("rst_freeze",   32'(bus.freeze_o),       0);
      next();
      idle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      next();

      // Load-use stall for one cycle.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("lu_pc_write", 32'(bus.PC_write_o),     0);
      chk("lu_ifid",     32'(bus.IF_ID_write_o),  0);
      chk("lu_bubble",   32'(bus.ID_EX_bubble_o), 1);
      next();
      idle();
      #2;
      chk("lu_after_pc",  32'(bus.PC_write_o),  1);
      chk("lu_stall_cnt", 32'(bus.stall_cnt_o), 1);

      // Match on the Rt source as well.
      drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
      #2;
      chk("lu_rt_bubble", 32'(bus.ID_EX_bubble_o), 1);
      next();

      // Register-0 load never stalls.
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("r0_pc_write", 32'(bus.PC_write_o),     1);
      chk("r0_bubble",   32'(bus.ID_EX_bubble_o), 0);
      next();
      idle();
      #2;
      chk("r0_stall_cnt", 32'(bus.stall_cnt_o), 2);

      // Memory wait: ack low for 3 cycles, then high.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
         #2;
         chk("mw_freeze_hi", 32'(bus.freeze_o), 1);
         next();
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      #2;
      chk("mw_freeze_ack", 32'(bus.freeze_o),   0);
      chk("mw_pc_ack",     32'(bus.PC_write_o), 1);
      next();
      idle();
      #2;
      chk("mw_stall_cnt", 32'(bus.stall_cnt_o), 3);

      // Timeout: ack never arrives.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
         #2;
         chk("to_freeze_hi", 32'(bus.freeze_o),      1);
         chk("to_err_lo",    32'(bus.mem_err_o),     0);
         chk("to_no_flush",  32'(bus.IF_ID_flush_o), 0);
         next();
      end
      idle();
      #2;
      chk("to_freeze_lo", 32'(bus.freeze_o),    0);
      chk("to_err_set",   32'(bus.mem_err_o),   1);
      chk("to_stall_cnt", 32'(bus.stall_cnt_o), 5);
      next();
      drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("to_lu_after_err", 32'(bus.ID_EX_bubble_o), 1);
      chk("to_err_sticky",   32'(bus.mem_err_o),      1);
      next();
      idle();
      next();

      // Load-use and taken branch together.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
      #2;
      chk("lb_flush_lo", 32'(bus.IF_ID_flush_o),  0);
      chk("lb_bubble",   32'(bus.ID_EX_bubble_o), 1);
      next();
      drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
      #2;
      chk("lb_flush_hi", 32'(bus.IF_ID_flush_o), 1);
      chk("lb_pc_write", 32'(bus.PC_write_o),    1);
      next();
      idle();
      #2;
      chk("lb_flush_cnt", 32'(bus.flush_cnt_o), 1);
      chk("lb_stall_cnt", 32'(bus.stall_cnt_o), 1);

      // Reset in the middle of a memory wait.
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      next();
      #2;
      chk("rw_freeze_pre", 32'(bus.freeze_o), 1);
      next();
      rst = 1'b1;
      #2;
      chk("rw_freeze",    32'(bus.freeze_o),    0);
      chk("rw_stall_cnt", 32'(bus.stall_cnt_o), 0);
      chk("rw_err",       32'(bus.mem_err_o),   0);
      next();
      rst = 1'b0;
      idle();
      #2;
      chk("rw_aborted", 32'(bus.freeze_o), 0);
      next();
      #2;
      chk("rw_err_after", 32'(bus.mem_err_o), 0);

      // Counter saturation.
      do_reset();
      drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) next();
      idle();
      #2;
      chk("sat_stall_cnt", 32'(bus.stall_cnt_o), MAXC);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) next();
      idle();
      #2;
      chk("sat_flush_cnt", 32'(bus.flush_cnt_o), MAXC);

      // Freeze overrides load-use and branch.
      do_reset();
      drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
      #2;
      chk("fo_flush",  32'(bus.IF_ID_flush_o),  0);
      chk("fo_bubble", 32'(bus.ID_EX_bubble_o), 0);
      chk("fo_pc",     32'(bus.PC_write_o),     0);
      next();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      next();
      idle();
      next();
      next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
